// File: rtl/control_motores.sv
// RGB timer initiator: converts an 8-bit colour to per-channel on-times, starts the
// timer, then walks the motors R->G->B on its flags with a per-phase watchdog.
module control_motores #(
  parameter int CW         = 5,
  parameter int SHIFT      = 3,
  parameter int MAX_CICLOS = 15,
  parameter int WD_LIMIT   = 20
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_color_valid,
  input  logic [7:0]    i_color_r,
  input  logic [7:0]    i_color_g,
  input  logic [7:0]    i_color_b,
  output logic          o_color_ready,
  output logic [CW-1:0] o_ciclos_R,
  output logic [CW-1:0] o_ciclos_G,
  output logic [CW-1:0] o_ciclos_B,
  output logic          o_enter,
  input  logic [2:0]    i_flags,
  output logic          o_motor_R,
  output logic          o_motor_G,
  output logic          o_motor_B,
  output logic          o_done,
  output logic          o_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN_R, S_RUN_G, S_RUN_B, S_FIN, S_ERR
  } state_t;

  localparam int              WDW     = $clog2(WD_LIMIT + 1);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(WD_LIMIT - 1);
  localparam logic [7:0]      MAXC8   = 8'(MAX_CICLOS);

  state_t         r_state;
  logic [WDW-1:0] r_wd;

  logic [CW-1:0]  w_cyc_r, w_cyc_g, w_cyc_b;
  logic           w_exp_flag;

  // Shift first, then clamp, so the result always fits the timer's counter.
  function automatic logic [CW-1:0] f_cycles(input logic [7:0] c);
    logic [7:0] v;
    v = c >> SHIFT;
    return (v > MAXC8) ? CW'(MAXC8) : CW'(v);
  endfunction

  assign w_cyc_r = f_cycles(i_color_r);
  assign w_cyc_g = f_cycles(i_color_g);
  assign w_cyc_b = f_cycles(i_color_b);

  // Only the current phase's flag matters; the others share the timer counter
  // and may be high spuriously.
  always_comb begin
    w_exp_flag = 1'b0;
    case (r_state)
      S_RUN_R: w_exp_flag = i_flags[2];
      S_RUN_G: w_exp_flag = i_flags[1];
      S_RUN_B: w_exp_flag = i_flags[0];
      default: w_exp_flag = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_wd          <= '0;
      o_ciclos_R    <= '0;
      o_ciclos_G    <= '0;
      o_ciclos_B    <= '0;
      o_color_ready <= 1'b1;
      o_enter       <= 1'b0;
      o_motor_R     <= 1'b0;
      o_motor_G     <= 1'b0;
      o_motor_B     <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      o_enter <= 1'b0;
      o_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_color_valid) begin
            o_ciclos_R    <= w_cyc_r;
            o_ciclos_G    <= w_cyc_g;
            o_ciclos_B    <= w_cyc_b;
            o_color_ready <= 1'b0;
            o_enter       <= 1'b1;
            r_state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_wd      <= '0;
          o_motor_R <= |o_ciclos_R;
          r_state   <= S_RUN_R;
        end
        S_RUN_R, S_RUN_G, S_RUN_B: begin
          // Flag wins over a watchdog expiry on the same edge.
          if (w_exp_flag) begin
            r_wd      <= '0;
            o_motor_R <= 1'b0;
            o_motor_G <= 1'b0;
            o_motor_B <= 1'b0;
            case (r_state)
              S_RUN_R: begin
                o_motor_G <= |o_ciclos_G;
                r_state   <= S_RUN_G;
              end
              S_RUN_G: begin
                o_motor_B <= |o_ciclos_B;
                r_state   <= S_RUN_B;
              end
              default: begin
                o_done  <= 1'b1;
                r_state <= S_FIN;
              end
            endcase
          end else if (r_wd == WD_LAST) begin
            o_motor_R <= 1'b0;
            o_motor_G <= 1'b0;
            o_motor_B <= 1'b0;
            o_error   <= 1'b1;
            r_state   <= S_ERR;
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
        end
        S_FIN: begin
          o_color_ready <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/control_motores.md
Name: control_motores

Overview:
- Initiator and consumer side of the RGB timer interface.
- Accepts a requested colour as 8-bit R/G/B intensities and converts each one to a motor on-time in clock cycles.
- Loads the three cycle counts into the timer, pulses its enter input, and consumes the timer flags phase by phase.
- Drives the three motor enables R→G→B and reports completion, or an error if the timer never answers.

Parameters:
- CW, 5: width of the ciclos_R/G/B outputs.
- SHIFT, 3: right-shift applied to each 8-bit intensity to get cycles.
- MAX_CICLOS, 15: saturation ceiling for each cycle count; matches the timer's 4-bit counter range.
- WD_LIMIT, 20: watchdog, the maximum number of cycles allowed in one RUN phase.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- color_valid, input, 1: colour request is present.
- color_r, input, 8: red intensity.
- color_g, input, 8: green intensity.
- color_b, input, 8: blue intensity.
- color_ready, output, 1: block can accept a request. High only in IDLE.
- ciclos_R, output, CW: red cycle count to the timer.
- ciclos_G, output, CW: green cycle count to the timer.
- ciclos_B, output, CW: blue cycle count to the timer.
- enter, output, 1: one-cycle start pulse to the timer.
- flags, input, 3: timer flags; [2]=R, [1]=G, [0]=B.
- motor_R, output, 1: red motor enable.
- motor_G, output, 1: green motor enable.
- motor_B, output, 1: blue motor enable.
- done, output, 1: one-cycle pulse when a full R/G/B sequence completes.
- error, output, 1: sticky watchdog error; cleared only by rst.

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- Reset values:
  - All outputs are 0, except color_ready = 1.
  - ciclos_R/G/B = 0; state = IDLE.
  - Reset applied mid-sequence: motors drop on the next edge; no done pulse.
- States: IDLE, LOAD, RUN_R, RUN_G, RUN_B, FIN, ERR.
- IDLE:
  - color_ready = 1.
  - A handshake occurs when color_valid = 1 on an edge. The block then latches, for each channel, ciclos_X = min(color_X >> SHIFT, MAX_CICLOS), zero-extended to CW, and goes to LOAD.
  - ciclos_* hold their values until the next accepted request.
- LOAD: enter = 1 for exactly this one cycle; next state RUN_R.
- RUN_R:
  - motor_R = 1 if ciclos_R != 0; 0 otherwise.
  - Exit condition is flags[2] = 1, sampled on an edge; next state RUN_G.
  - flags[1:0] are ignored in this state, because the timer's flags share one counter and may be spuriously high.
  - Expected duration is ciclos_R + 1 cycles. A zero count still costs 1 cycle, with the motor off.
- RUN_G: same rules as RUN_R, using motor_G and flags[1]; next state RUN_B.
- RUN_B: same rules, using motor_B and flags[0]; next state FIN.
- FIN: done = 1 for one cycle, all motors off; next state IDLE.
- Motors:
  - At most one motor is on at any time.
  - Motor outputs are registered or decoded from state only; no combinational path from flags.
- Watchdog:
  - A phase counter resets on entering each RUN state.
  - If the counter reaches WD_LIMIT without the expected flag: go to ERR, all motors off, error = 1.
  - ERR is held until rst; color_ready = 0 in ERR.
- Simultaneous events:
  - color_valid is ignored outside IDLE, with no queuing.
  - The expected flag on the same edge as the watchdog limit counts as success (flag has priority).
- Width rule: the shift is done before saturation; the result never exceeds MAX_CICLOS.

Test Plan:
- Basic sequence:
  - Stimulus: color 0x40/0x20/0x08 with a behavioural timer model.
  - Response: ciclos = 8/4/1; enter pulses once; motor_R high 9 cycles, motor_G 5, motor_B 2; done pulses once; color_ready returns to 1.
- Saturation:
  - Stimulus: color 0xFF/0x80/0x00.
  - Response: ciclos = 15/15/0; RUN_B lasts 1 cycle with motor_B = 0; done pulses.
- Spurious flags:
  - Stimulus: flags[1:0] forced to 1 throughout RUN_R.
  - Response: motor_R is unaffected; the R phase length equals ciclos_R + 1.
- Watchdog:
  - Stimulus: flags stuck at 0 after LOAD.
  - Response: after 20 cycles in RUN_R, motor_R = 0 and error = 1; the error stays set; a new color_valid is not accepted until rst.
- Reset mid-RUN_G:
  - Stimulus: assert rst during RUN_G.
  - Response: on the next edge all motors = 0, ciclos = 0, no done pulse, color_ready = 1.
- Busy rejection:
  - Stimulus: color_valid held high with a new colour during RUN_R.
  - Response: the latched ciclos are unchanged; the new colour is accepted only in the first IDLE cycle after FIN.
